uart_rx_os: RTL

- 8N1 UART receiver. Consumes the oversampling tick from the baud rate generator (`rxclk_en`, OVERSAMPLE ticks per bit).
- Resynchronises the serial line, detects the start bit and majority-votes each bit at mid-period.
- Delivers bytes through a one-entry valid/ready output buffer to the pCPU UART peripheral register file.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// geometry, 8N1 line levels and the 2-of-3 vote helper.
package uart_pkg;

    localparam int OS_DEF    = 8;
    localparam int DBITS_DEF = 8;

    // 8N1 line levels
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } rx_state_t;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, reset to line idle.
// Ports: i_clk, i_rst_n (async, active low), i_d (async in), o_q (synced).
module sync_2ff
    import uart_pkg::*;
#(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{IDLE_LVL}}
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with 3-sample mid-bit majority vote
// and a one-entry valid/ready output buffer.
// Ports: clk, rst (async, active low), rx_tick (oversample enable),
//   rx_in (raw line), rx_data/rx_valid/rx_ready (output handshake),
//   frame_err, overrun (1-clk pulses), busy (not IDLE).
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OS_DEF,
    parameter int DATA_BITS  = DBITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_V0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_V1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_V2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    logic w_rx_s;

    sync_2ff #(
        .W       (1),
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx_in),
        .o_q     (w_rx_s)
    );

    rx_state_t            r_state, w_state_n;
    logic [CW-1:0]        r_cnt, w_cnt_n;
    logic [IW-1:0]        r_idx, w_idx_n;
    logic [DATA_BITS-1:0] r_shreg, w_shreg_n;
    logic [2:0]           r_smp, w_smp_n;
    logic [DATA_BITS-1:0] r_data, w_data_n;
    logic                 r_valid, w_valid_n;
    logic                 r_ferr, w_ferr_n;
    logic                 r_ovr, w_ovr_n;
    logic                 w_vote;
    logic                 w_vote_stop;
    logic                 w_deliver;

    assign w_vote = maj3(r_smp[0], r_smp[1], r_smp[2]);
    // STOP decides on the third sample itself, so use the live value
    assign w_vote_stop = maj3(r_smp[0], r_smp[1], w_rx_s);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shreg_n = r_shreg;
        w_smp_n   = r_smp;
        w_data_n  = r_data;
        w_valid_n = r_valid;
        w_ferr_n  = 1'b0;
        w_ovr_n   = 1'b0;
        w_deliver = 1'b0;

        if (rx_tick && (r_state != S_IDLE)) begin
            if (r_cnt == C_V0) w_smp_n[0] = w_rx_s;
            if (r_cnt == C_V1) w_smp_n[1] = w_rx_s;
            if (r_cnt == C_V2) w_smp_n[2] = w_rx_s;
        end

        if (rx_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rx_s == START_LVL) begin
                        w_state_n = S_START;
                        w_cnt_n   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == C_LAST) begin
                        w_cnt_n = '0;
                        if (w_vote != START_LVL) begin
                            w_state_n = S_IDLE;
                        end else begin
                            w_state_n = S_DATA;
                            w_idx_n   = '0;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        w_cnt_n   = '0;
                        w_shreg_n = {w_vote, r_shreg[DATA_BITS-1:1]};
                        if (r_idx == I_LAST) begin
                            w_state_n = S_STOP;
                        end else begin
                            w_idx_n = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // leave mid stop bit so a back-to-back start is seen
                    if (r_cnt == C_V2) begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = '0;
                        if (w_vote_stop != STOP_LVL) begin
                            w_ferr_n = 1'b1;
                        end else if (!r_valid || rx_ready) begin
                            w_deliver = 1'b1;
                        end else begin
                            w_ovr_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end

        if (w_deliver) begin
            w_data_n  = r_shreg;
            w_valid_n = 1'b1;
        end else if (r_valid && rx_ready) begin
            w_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_smp   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shreg <= w_shreg_n;
            r_smp   <= w_smp_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
            r_ovr   <= w_ovr_n;
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = (r_state != S_IDLE);

endmodule
